// File: rtl/int_ctrl.sv
// int_ctrl: 16-source edge-triggered priority interrupt controller with an MIO slave port.
module int_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irq_in,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        int_out,
  output logic [31:0] cause_out
);

  localparam int unsigned NSRC = 16;
  localparam int unsigned IDXW = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned SELW = 3;

  localparam logic [SELW-1:0] REG_PEND  = 3'd0;
  localparam logic [SELW-1:0] REG_EN    = 3'd1;
  localparam logic [SELW-1:0] REG_CAUSE = 3'd2;
  localparam logic [SELW-1:0] REG_ACK   = 3'd3;
  localparam logic [SELW-1:0] REG_SWSET = 3'd4;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [NSRC-1:0]   s1, s2, s3;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   enable;
  logic [NSRC-1:0]   active;
  logic [NSRC-1:0]   clr;
  logic [NSRC-1:0]   swset;
  logic              en_load;
  logic [IDXW-1:0]   win_idx;
  logic [DW-1:0]     rd_val;
  logic [SELW-1:0]   sel;
  logic              unused_bits;

  assign sel         = addr[4:2];
  assign rise        = s2 & ~s3;
  assign active      = pending & enable;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  // Two-flop synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Bus FSM next state; an access is only accepted from IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (cs && (we || re)) begin
          state_next = RESP;
          accept     = 1'b1;
        end
      end
      RESP:    state_next = cs ? HOLD : IDLE;
      HOLD:    if (!cs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write side effects, active only on the accepting edge.
  always_comb begin
    clr     = '0;
    swset   = '0;
    en_load = 1'b0;
    if (accept && we) begin
      case (sel)
        REG_PEND:  clr     = wdata[NSRC-1:0];
        REG_EN:    en_load = 1'b1;
        REG_ACK:   if (int_out) clr = NSRC'(1) << cause_out[IDXW-1:0];
        REG_SWSET: swset   = wdata[NSRC-1:0];
        default:   ;
      endcase
    end
  end

  // Pending and enable registers; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= (pending & ~clr) | rise | swset;
      if (en_load) enable <= wdata[NSRC-1:0];
    end
  end

  // Lowest set index of active wins.
  always_comb begin
    logic found;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (active[i] && !found) begin
        win_idx = IDXW'(i);
        found   = 1'b1;
      end
    end
  end

  // Registered interrupt request and cause towards the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_out   <= 1'b0;
      cause_out <= '0;
    end else begin
      int_out   <= |active;
      cause_out <= (|active) ? DW'(win_idx) : '0;
    end
  end

  // Register read mux, evaluated on pre-write state.
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_PEND:  rd_val = DW'(pending);
      REG_EN:    rd_val = DW'(enable);
      REG_CAUSE: rd_val = {int_out, 27'b0, cause_out[IDXW-1:0]};
      default:   rd_val = '0;
    endcase
  end

  // Handshake and read data; rdata is zero whenever ready is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= (state_next != IDLE);
      if (accept)                   rdata <= rd_val;
      else if (state_next == IDLE)  rdata <= '0;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a cycle-level behavioural model and literal spot checks.
`timescale 1ns/1ps
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irq_in;
  logic        cs, we, re;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        int_out;
  logic [31:0] cause_out;

  int tests = 0;
  int fails = 0;

  int_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .cs(cs), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .int_out(int_out), .cause_out(cause_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // samp1..3: irq_in as seen at the last three rising edges (most recent first).
  logic [15:0] m_pend, m_en, samp1, samp2, samp3;
  logic        m_int, m_busy;
  logic [3:0]  m_cause;
  logic [31:0] m_rdata;

  always @(posedge clk or negedge reset) begin
    logic [15:0] rise, clr, sw, act, new_en;
    logic        n_int;
    logic [3:0]  n_cause;
    if (!reset) begin
      m_pend = '0; m_en = '0; m_int = 0; m_cause = '0; m_busy = 0; m_rdata = '0;
      samp1 = '0; samp2 = '0; samp3 = '0;
    end else begin
      // an edge is latched two samples after it is first seen high
      rise = samp2 & ~samp3;
      clr = '0; sw = '0; new_en = m_en;
      if (!m_busy && cs && (we || re)) begin
        m_busy = 1;
        case (addr[4:2])
          3'd0:    m_rdata = {16'b0, m_pend};
          3'd1:    m_rdata = {16'b0, m_en};
          3'd2:    m_rdata = {m_int, 27'b0, m_cause};
          default: m_rdata = '0;
        endcase
        if (we) begin
          case (addr[4:2])
            3'd0: clr = wdata[15:0];
            3'd1: new_en = wdata[15:0];
            3'd3: if (m_int) clr[m_cause] = 1'b1;
            3'd4: sw = wdata[15:0];
            default: ;
          endcase
        end
      end else if (m_busy && !cs) begin
        m_busy = 0;
        m_rdata = '0;
      end
      act = m_pend & m_en;
      n_int = (act != 0);
      n_cause = '0;
      for (int i = 15; i >= 0; i--) if (act[i]) n_cause = 4'(i);
      m_pend  = (m_pend & ~clr) | rise | sw;
      m_en    = new_en;
      m_int   = n_int;
      m_cause = n_cause;
      samp3 = samp2; samp2 = samp1; samp1 = irq_in;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("model_int_out", {31'b0, int_out}, {31'b0, m_int});
      chk("model_cause",   cause_out, {28'b0, m_cause});
      chk("model_ready",   {31'b0, ready}, {31'b0, m_busy});
      chk("model_rdata",   rdata, m_rdata);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    cs = 1; we = 1; addr = a; wdata = d;
    repeat (hold) @(negedge clk);
    cs = 0; we = 0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1; re = 1; addr = a;
    @(negedge clk);
    d = rdata;
    chk("read_ready", {31'b0, ready}, 32'd1);
    cs = 0; re = 0;
  endtask

  task automatic read_expect(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; irq_in = '0; cs = 0; we = 0; re = 0; addr = '0; wdata = '0;

    // Reset: all outputs zero
    repeat (3) @(negedge clk);
    chk("rst_int",   {31'b0, int_out}, 32'd0);
    chk("rst_cause", cause_out, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1;

    // Basic raise
    bus_write(5'h04, 32'h0001, 1);
    @(negedge clk);
    irq_in[0] = 1;
    repeat (3) @(posedge clk);
    #1 chk("raise_edge3_int", {31'b0, int_out}, 32'd0);
    @(negedge clk);
    irq_in[0] = 0;
    @(posedge clk);
    #1 chk("raise_edge4_int", {31'b0, int_out}, 32'd1);
    chk("raise_edge4_cause", cause_out, 32'h0);
    read_expect("raise_pending", 5'h00, 32'h0001);
    read_expect("raise_causereg", 5'h08, 32'h8000_0000);
    bus_write(5'h00, 32'h0001, 1);
    read_expect("raise_cleared", 5'h00, 32'h0);

    // Priority
    bus_write(5'h04, 32'hFFFF, 1);
    @(negedge clk);
    irq_in[5] = 1; irq_in[9] = 1;
    repeat (4) @(posedge clk);
    #1 chk("prio_cause5", cause_out, 32'd5);
    @(negedge clk);
    irq_in = '0;
    bus_write(5'h0C, 32'h0, 1);
    @(posedge clk);
    #1 chk("prio_cause9", cause_out, 32'd9);
    chk("prio_int_still", {31'b0, int_out}, 32'd1);
    bus_write(5'h0C, 32'h0, 1);
    @(posedge clk);
    #1 chk("prio_int_off", {31'b0, int_out}, 32'd0);
    read_expect("prio_ack_read", 5'h0C, 32'h0);

    // Masking
    bus_write(5'h04, 32'h0000, 1);
    @(negedge clk);
    irq_in[3] = 1;
    repeat (5) @(posedge clk);
    #1 chk("mask_int_off", {31'b0, int_out}, 32'd0);
    @(negedge clk);
    irq_in = '0;
    read_expect("mask_pending", 5'h00, 32'h0008);
    bus_write(5'h04, 32'h0008, 1);
    @(posedge clk);
    #1 chk("mask_int_on", {31'b0, int_out}, 32'd1);
    chk("mask_cause3", cause_out, 32'd3);
    read_expect("mask_enable", 5'h04, 32'h0008);
    bus_write(5'h00, 32'h0008, 1);

    // Set/clear collision: W1C accepted on the edge where rise[2] is high
    @(negedge clk);
    irq_in[2] = 1;
    @(negedge clk);
    @(negedge clk);
    cs = 1; we = 1; addr = 5'h00; wdata = 32'h0004;
    @(negedge clk);
    cs = 0; we = 0; irq_in = '0;
    read_expect("collide_pending", 5'h00, 32'h0004);
    bus_write(5'h00, 32'h0004, 1);
    read_expect("collide_cleared", 5'h00, 32'h0);

    // Held-strobe SWSET
    @(negedge clk);
    cs = 1; we = 1; addr = 5'h10; wdata = 32'h0010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("held_ready", {31'b0, ready}, 32'd1);
    end
    @(negedge clk);
    cs = 0; we = 0;
    @(posedge clk);
    #1 chk("held_ready_drop", {31'b0, ready}, 32'd0);
    read_expect("held_pending", 5'h00, 32'h0010);
    read_expect("held_swset_read", 5'h10, 32'h0);
    read_expect("held_reserved", 5'h18, 32'h0);
    bus_write(5'h00, 32'h0010, 1);
    read_expect("held_cleared", 5'h00, 32'h0);

    // Held ACK: must clear only one source
    bus_write(5'h10, 32'h0003, 1);
    bus_write(5'h04, 32'h0003, 1);
    @(negedge clk);
    bus_write(5'h0C, 32'h0, 3);
    read_expect("held_ack_once", 5'h00, 32'h0002);
    bus_write(5'h00, 32'h0002, 1);

    // Reset mid-access while in HOLD
    bus_write(5'h04, 32'h00FF, 1);
    @(negedge clk);
    cs = 1; re = 1; addr = 5'h04;
    @(posedge clk);
    @(posedge clk);
    #1 chk("hold_ready", {31'b0, ready}, 32'd1);
    chk("hold_rdata", rdata, 32'h00FF);
    #2 reset = 0;
    #1 chk("midrst_ready", {31'b0, ready}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    cs = 0; re = 0;
    @(negedge clk);
    reset = 1;
    read_expect("midrst_enable", 5'h04, 32'h0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped, 16-source priority interrupt controller that sits directly upstream of the multi-cycle CPU. It edge-detects device interrupt lines and latches them as pending. It drives the CPU's `INT` and `Cause_in` inputs with the highest-priority enabled pending source. Software reads, masks and acknowledges sources over the CPU's memory/IO bus, using the same ready handshake as other MIO slaves.

## Interface
- `NSRC`, 16: number of interrupt sources. Fixed at 16 to match the CPU's 4-to-16 cause decode.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. All registers clear while low.
- `irq_in` input 16: raw device interrupt lines, asynchronous to `clk`. Bit 0 has the highest priority.
- `cs` input 1: slave select from the bus decoder.
- `we` input 1: write strobe. Qualified by `cs`.
- `re` input 1: read strobe. Qualified by `cs`.
- `addr` input 5: byte offset. Bits [4:2] select the register; bits [1:0] are ignored.
- `wdata` input 32: write data (CPU `Data_out`).
- `rdata` output 32: read data. Valid while `ready`=1, 0 otherwise.
- `ready` output 1: access-complete handshake (drives the CPU's `MIO_ready`).
- `int_out` output 1: interrupt request (drives CPU `INT`).
- `cause_out` output 32: bits [3:0] carry the winning source index; bits [31:4] are 0 (drives CPU `Cause_in`).

## Operation
- Synchroniser and edge detect:
  - Each `irq_in` bit passes through two flops (`s1`, `s2`) plus a history flop `s3`.
  - `rise = s2 & ~s3`.
- `pending[15:0]` update, evaluated in order each cycle: `pending_next = (pending & ~clr) | rise | swset`.
  - Setting always wins over clearing in the same cycle, so a new edge is never lost.
- `enable[15:0]`: the mask register, reset to 0.
- `active = pending & enable`. The winner is the lowest set bit index of `active`.
- `int_out` and `cause_out` are registered from `active` and the winner every cycle:
  - `int_out` = |active.
  - `cause_out` = {28'b0, idx} when `active` != 0; otherwise `cause_out` = 0.
- Register map:
  - 0x00 PENDING: read returns {16'b0, pending}. A write clears each bit that is 1 in `wdata[15:0]` (write-1-to-clear).
  - 0x04 ENABLE: read/write, {16'b0, enable}.
  - 0x08 CAUSE: read returns {int_out, 27'b0, cause_out[3:0]}. Writes are ignored.
  - 0x0C ACK: a write clears `pending[cause_out[3:0]]` if `int_out`=1; otherwise it has no effect. Reads return 0.
  - 0x10 SWSET: a write sets the pending bits given by `wdata[15:0]` (software trigger). Reads return 0.
  - 0x14–0x1C: reserved. Reads return 0 and writes are ignored.
- Bus FSM, states IDLE, RESP, HOLD:
  - IDLE → RESP when `cs & (we|re)`. The write side effect (`clr`/`swset`/`enable` update) is applied exactly once, on this edge. Read data is captured into `rdata` on the same edge.
  - RESP: `ready`=1. If `cs` is still high, go to HOLD; otherwise go to IDLE.
  - HOLD: `ready`=1 and `rdata` is held. Stay in HOLD while `cs`=1. Go to IDLE when `cs`=0.
  - No second access is accepted until the FSM has returned to IDLE. This makes a master that holds its strobes across several cycles safe.
  - If `we` and `re` are both high, the access is treated as a write. `rdata` then returns the register value as it was before the write.

## Timing
- Reset (`reset`=0) asynchronously clears:
  - `s1`, `s2`, `s3`, `pending` and `enable` to 0;
  - `int_out`=0, `cause_out`=0, `ready`=0, `rdata`=0;
  - the FSM to IDLE.
- Reset asserted in the middle of an access aborts it. No write effect occurs unless the IDLE→RESP edge has already happened.
- Interrupt latency: when `irq_in[k]` is high before edge 1, the chain updates as follows:
  - `s1` goes high at edge 1 and `s2` at edge 2;
  - `pending[k]` sets at edge 3;
  - `int_out`/`cause_out` update at edge 4.
- Edge detection: `irq_in` held high produces a single `pending` set. A pulse must be high for at least 2 clocks to be guaranteed detection.
- Clear latency: an ACK or PENDING W1C applied at edge n is reflected in `int_out`/`cause_out` at edge n+1.
- Access latency: with `cs` and strobe asserted before edge n, `ready` is high after edge n, for at least one cycle.
- A disabled pending source remains pending. It raises `int_out` one edge after its enable bit is written.

## Test plan
- Reset and basic raise:
  - Hold `reset` low: all outputs are 0.
  - Release reset, write ENABLE=0x0001, then pulse `irq_in[0]` high for 3 clocks.
  - Required: `int_out`=1 and `cause_out`=0x00000000 at edge 4 after the pulse starts; PENDING reads 0x0001.
- Priority:
  - With ENABLE=0xFFFF, raise `irq_in[5]` and `irq_in[9]` together: `cause_out`=5.
  - Write ACK: `cause_out`=9 on the next edge.
  - Write ACK again: `int_out`=0.
- Masking:
  - With ENABLE=0x0000, raise `irq_in[3]`: `int_out` stays 0 and PENDING=0x0008.
  - Write ENABLE=0x0008: `int_out`=1 and `cause_out`=3 one edge later.
- Set/clear collision: write PENDING W1C=0x0004 on the same cycle that `rise[2]`=1. Required: `pending[2]` remains 1.
- Held-strobe handshake:
  - Hold `cs`/`we` high for 4 cycles writing SWSET=0x0010.
  - Required: `ready` is high from cycle 1 until `cs` drops; `pending[4]` sets once.
  - Then W1C 0x0010: PENDING reads 0.
- Reset mid-access: assert `reset` low while in HOLD. Required: `ready`=0 immediately, the FSM is in IDLE, and ENABLE=0.
